alu_writeback: RTL
==================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, 8: width of result and register data.
REQ-002 Parameter NUM_REGS, 4: number of architectural registers; REG_AW = clog2(NUM_REGS).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 res_valid  in  1  result from the 6:1 op-select mux is present.
REQ-006 res_ready  out  1  block can accept a result this cycle.
REQ-007 res_data  in  DATA_W  selected ALU result.
REQ-008 res_sel  in  3  op select that produced res_data (000..101 legal).
REQ-009 res_carry  in  1  carry/borrow out of the arithmetic ops.
REQ-010 res_dst  in  REG_AW  destination register index.
REQ-011 rd_addr_a, rd_addr_b  in  REG_AW  operand read addresses.
REQ-012 rd_data_a, rd_data_b  out  DATA_W  combinational operand read data.
REQ-013 flag_z, flag_n, flag_c  out  1  zero, negative, carry flags.
REQ-014 err  out  1  sticky illegal-select flag.
REQ-015 err_clr  in  1  clears err.
REQ-016 wb_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM SHALL have states IDLE, HOLD, COMMIT, encoded in 2 bits.
REQ-018 res_ready SHALL be 1 only in IDLE; a transfer occurs when res_valid && res_ready.
REQ-019 On a transfer, the block SHALL latch res_data, res_sel, res_carry and res_dst into a holding register and move IDLE->HOLD.
REQ-020 HOLD SHALL always move to COMMIT on the next cycle; COMMIT SHALL always move to IDLE; transfer-to-visible latency is 3 cycles, throughput is one result per 3 cycles.
REQ-021 In COMMIT with a legal held select, regfile[dst] SHALL be written with the held data, and flag_z = (data == 0) and flag_n = data[DATA_W-1] SHALL be updated.
REQ-022 flag_c SHALL be updated from the held carry only when the held select is 000 or 001 (arithmetic ops); otherwise it holds.
REQ-023 In COMMIT with held select 110 or 111, no register or flag SHALL change and err SHALL be set.
REQ-024 err_clr SHALL clear err; if it coincides with a setting COMMIT, set SHALL win.
REQ-025 Reads SHALL be combinational from the regfile; a read of the register being written in COMMIT returns the old value unless WB_BYPASS_EN is defined.
REQ-026 res_valid while not in IDLE SHALL be ignored; upstream holds data until accepted.

Reset
REQ-027 On rst_n low, asynchronously: FSM=IDLE, all registers=0, holding register=0, flag_z=1, flag_n=0, flag_c=0, err=0.
REQ-028 Reset asserted in HOLD or COMMIT SHALL discard the held result with no register write.
REQ-029 After reset release, res_ready SHALL be 1 on the first clock.

Configuration
REQ-030 Macro WB_BYPASS_EN defined: rd_data_a/b SHALL return the held data when FSM is HOLD or COMMIT, the held select is legal and rd_addr equals the held dst.
REQ-031 Macro WB_BYPASS_EN undefined: no forwarding; reads return regfile contents only.

Structure
REQ-032 Package wb_pkg SHALL hold the FSM state typedef, the 3-bit select constants SEL_0..SEL_5, and the illegal-select check function.
REQ-033 The register array with two async read ports and one write port SHALL be sub-module wb_regfile.

Verification
REQ-034 Reset, then transfer data 0x00, sel 010, dst 1 -> after 3 cycles r1=0x00, flag_z=1, flag_n=0, flag_c unchanged (0).
REQ-035 Transfer data 0x80, sel 000, carry 1, dst 2 -> r2=0x80, flag_n=1, flag_z=0, flag_c=1; res_ready low for exactly 2 cycles after the transfer.
REQ-036 Transfer sel 111, data 0x55, dst 3 -> r3 stays 0, flags unchanged, err=1; err_clr pulse -> err=0.
REQ-037 Transfer 0x3C to dst 0 with rd_addr_a=0 held -> in HOLD, rd_data_a=0x3C with WB_BYPASS_EN, 0x00 without.
REQ-038 Transfer, then assert rst_n low during HOLD -> no write, all registers 0, FSM IDLE, res_ready=1 after release.
REQ-039 Back-to-back res_valid held high with four results -> exactly four commits, one every 3 cycles, none dropped or duplicated.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the ALU write-back stage.
//   wb_state_t   : write-back FSM state (IDLE, HOLD, COMMIT), 2-bit encoding
//   SEL_0..SEL_5 : legal 3-bit op-select codes from the 6:1 result mux
//   sel_illegal  : true for select codes 110 and 111
//   sel_arith    : true for the arithmetic selects (000, 001) that drive carry
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_COMMIT = 2'd2
  } wb_state_t;

  localparam logic [2:0] SEL_0 = 3'd0;
  localparam logic [2:0] SEL_1 = 3'd1;
  localparam logic [2:0] SEL_2 = 3'd2;
  localparam logic [2:0] SEL_3 = 3'd3;
  localparam logic [2:0] SEL_4 = 3'd4;
  localparam logic [2:0] SEL_5 = 3'd5;

  function automatic logic sel_illegal(input logic [2:0] sel);
    return (sel > SEL_5);
  endfunction

  function automatic logic sel_arith(input logic [2:0] sel);
    return (sel == SEL_0) || (sel == SEL_1);
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// wb_regfile: architectural register array, one write port, two
// combinational read ports. All entries clear on asynchronous reset.
//   clk, rst_n     : clock, async active-low reset
//   we, wa, wd     : write enable / address / data (written on rising edge)
//   ra_a, ra_b     : read addresses
//   rd_a, rd_b     : read data (old value during a same-cycle write)
module wb_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: accepts one ALU result at a time, holds it for a cycle,
// then commits it to the register file and updates the Z/N/C flags.
// Optional macro WB_BYPASS_EN forwards the held result to the read ports
// while it is in flight (HOLD or COMMIT).
//
// Handshake: a result transfers on a rising edge where res_valid && res_ready.
// res_ready is high only in IDLE; upstream keeps res_data/res_sel/res_carry/
// res_dst stable until it sees the transfer. res_valid outside IDLE is ignored.
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   res_valid/res_ready        : result handshake
//   res_data/sel/carry/dst     : result payload
//   rd_addr_a/b, rd_data_a/b   : combinational operand reads
//   flag_z, flag_n, flag_c     : status flags
//   err, err_clr               : sticky illegal-select flag and its clear
//   wb_busy                    : FSM not in IDLE
//   dbg_state                  : current FSM state
module alu_writeback
  import wb_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int REG_AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [2:0]        res_sel,
  input  logic              res_carry,
  input  logic [REG_AW-1:0] res_dst,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              err,
  input  logic              err_clr,
  output logic              wb_busy,
  output wb_state_t         dbg_state
);

  wb_state_t         state;
  logic [DATA_W-1:0] hold_data;
  logic [2:0]        hold_sel;
  logic              hold_carry;
  logic [REG_AW-1:0] hold_dst;

  logic              hold_bad;
  logic              commit_we;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  assign hold_bad  = sel_illegal(hold_sel);
  assign commit_we = (state == ST_COMMIT) && !hold_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold_data  <= '0;
      hold_sel   <= '0;
      hold_carry <= 1'b0;
      hold_dst   <= '0;
      flag_z     <= 1'b1;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (res_valid) begin
            hold_data  <= res_data;
            hold_sel   <= res_sel;
            hold_carry <= res_carry;
            hold_dst   <= res_dst;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: state <= ST_COMMIT;
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (!hold_bad) begin
            flag_z <= (hold_data == '0);
            flag_n <= hold_data[DATA_W-1];
            if (sel_arith(hold_sel)) flag_c <= hold_carry;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Setting the error on an illegal commit takes priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == ST_COMMIT) && hold_bad) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign res_ready = (state == ST_IDLE);
  assign wb_busy   = (state != ST_IDLE);
  assign dbg_state = state;

  wb_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_we),
    .wa    (hold_dst),
    .wd    (hold_data),
    .ra_a  (rd_addr_a),
    .ra_b  (rd_addr_b),
    .rd_a  (rf_a),
    .rd_b  (rf_b)
  );

`ifdef WB_BYPASS_EN
  logic fwd;
  assign fwd       = wb_busy && !hold_bad;
  assign rd_data_a = (fwd && (rd_addr_a == hold_dst)) ? hold_data : rf_a;
  assign rd_data_b = (fwd && (rd_addr_b == hold_dst)) ? hold_data : rf_b;
`else
  assign rd_data_a = rf_a;
  assign rd_data_b = rf_b;
`endif

endmodule
